// File: rtl/sha2_padding_eddsa_if.sv
// Stream-in / block-out signal bundle for sha2_padding_eddsa.
// With SHA2_PAD_BLKCNT_EN defined the bundle also carries the blk_cnt block index.
interface sha2_padding_eddsa_if #(
  parameter int WIDTH = 32
);
  localparam int BW = $clog2(WIDTH / 8) + 1;

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic [BW-1:0]    s_bytes;
  logic             blk_ready;
  logic             load;
  logic [WIDTH-1:0] data_out;
  logic             blk_first;
  logic             blk_done;
  logic             msg_done;
`ifdef SHA2_PAD_BLKCNT_EN
  logic [15:0]      blk_cnt;
`endif

  modport master (
    output s_valid, s_data, s_last, s_bytes, blk_ready,
`ifdef SHA2_PAD_BLKCNT_EN
    input  blk_cnt,
`endif
    input  s_ready, load, data_out, blk_first, blk_done, msg_done
  );

  modport slave (
    input  s_valid, s_data, s_last, s_bytes, blk_ready,
`ifdef SHA2_PAD_BLKCNT_EN
    output blk_cnt,
`endif
    output s_ready, load, data_out, blk_first, blk_done, msg_done
  );
endinterface

// File: rtl/sha2_padding_eddsa.sv
// FIPS 180-4 message padder feeding the SHA-2 schedule load port, 16 words per block.
// Optional SHA2_PAD_BLKCNT_EN exposes a saturating per-message block index on blk_cnt.
module sha2_padding_eddsa #(
  parameter int WIDTH = 32,
  parameter int MODE  = 256
) (
  input logic                 clk,
  input logic                 rst,
  sha2_padding_eddsa_if.slave bus
);
  localparam int unsigned    NB    = WIDTH / 8;
  localparam int             BLW   = 2 * WIDTH;
  localparam logic [WIDTH-1:0] PAD80 = {8'h80, {(WIDTH - 8){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MSG, S_PADW, S_ZERO, S_LEN, S_BWAIT} state_t;

  if (!((WIDTH == 32 && (MODE == 224 || MODE == 256)) ||
        (WIDTH == 64 && (MODE == 384 || MODE == 512)))) begin : g_cfg_err
    $error("sha2_padding_eddsa: MODE does not match WIDTH");
  end

  state_t           r_state, r_resume;
  logic [3:0]       r_wcnt;
  logic [BLW-1:0]   r_bitlen;
  logic             r_first;
  logic             r_load, r_blk_first, r_blk_done, r_msg_done;
  logic [WIDTH-1:0] r_data;

  state_t           w_state_nxt, w_resume_nxt, w_pad_nxt;
  logic             w_emit, w_accept, w_start, w_msg_end;
  logic [WIDTH-1:0] w_word, w_pad_word;
  logic [31:0]      w_nbytes;

  assign w_nbytes = 32'(bus.s_bytes);

  always_comb begin
    w_pad_word = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (b < w_nbytes)
        w_pad_word[WIDTH-1-8*b -: 8] = bus.s_data[WIDTH-1-8*b -: 8];
      else if (b == w_nbytes)
        w_pad_word[WIDTH-1-8*b -: 8] = 8'h80;
    end
  end

  // After the 0x80 word: length fits only if word 13 was the pad word or earlier;
  // pad at 14/15 spills into an extra all-zero block via ZERO/BWAIT.
  always_comb begin
    w_state_nxt  = r_state;
    w_resume_nxt = r_resume;
    w_emit       = 1'b0;
    w_accept     = 1'b0;
    w_start      = 1'b0;
    w_msg_end    = 1'b0;
    w_word       = '0;
    if (r_wcnt == 4'd13)      w_pad_nxt = S_LEN;
    else if (r_wcnt == 4'd15) w_pad_nxt = S_BWAIT;
    else                      w_pad_nxt = S_ZERO;
    case (r_state)
      S_IDLE: begin
        if (bus.blk_ready) begin
          w_start     = 1'b1;
          w_state_nxt = S_MSG;
        end
      end
      S_MSG: begin
        if (bus.s_valid) begin
          w_accept = 1'b1;
          w_emit   = 1'b1;
          if (!bus.s_last || w_nbytes >= NB) begin
            w_word = bus.s_data;
            if (r_wcnt == 4'd15) begin
              w_state_nxt  = S_BWAIT;
              w_resume_nxt = bus.s_last ? S_PADW : S_MSG;
            end else if (bus.s_last) begin
              w_state_nxt = S_PADW;
            end
          end else begin
            w_word       = w_pad_word;
            w_state_nxt  = w_pad_nxt;
            w_resume_nxt = S_ZERO;
          end
        end
      end
      S_PADW: begin
        w_emit       = 1'b1;
        w_word       = PAD80;
        w_state_nxt  = w_pad_nxt;
        w_resume_nxt = S_ZERO;
      end
      S_ZERO: begin
        w_emit = 1'b1;
        if (r_wcnt == 4'd13) begin
          w_state_nxt = S_LEN;
        end else if (r_wcnt == 4'd15) begin
          w_state_nxt  = S_BWAIT;
          w_resume_nxt = S_ZERO;
        end
      end
      S_LEN: begin
        w_emit = 1'b1;
        w_word = r_wcnt[0] ? r_bitlen[WIDTH-1:0] : r_bitlen[BLW-1:WIDTH];
        if (r_wcnt == 4'd15) begin
          w_msg_end   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_BWAIT: begin
        if (bus.blk_ready) w_state_nxt = r_resume;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_resume    <= S_MSG;
      r_wcnt      <= '0;
      r_bitlen    <= '0;
      r_first     <= 1'b0;
      r_load      <= 1'b0;
      r_data      <= '0;
      r_blk_first <= 1'b0;
      r_blk_done  <= 1'b0;
      r_msg_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_resume    <= w_resume_nxt;
      r_load      <= w_emit;
      r_blk_first <= w_emit & r_first;
      r_blk_done  <= w_emit && (r_wcnt == 4'd15);
      r_msg_done  <= w_msg_end;
      if (w_emit) begin
        r_data <= w_word;
        r_wcnt <= r_wcnt + 4'd1;
        if (r_wcnt == 4'd15) r_first <= 1'b0;
      end
      if (w_start) begin
        r_bitlen <= '0;
        r_first  <= 1'b1;
        r_wcnt   <= '0;
      end else if (w_accept) begin
        if (bus.s_last) r_bitlen <= r_bitlen + (BLW'(w_nbytes) << 3);
        else            r_bitlen <= r_bitlen + BLW'(WIDTH);
      end
    end
  end

  assign bus.s_ready   = (r_state == S_MSG);
  assign bus.load      = r_load;
  assign bus.data_out  = r_data;
  assign bus.blk_first = r_blk_first;
  assign bus.blk_done  = r_blk_done;
  assign bus.msg_done  = r_msg_done;

`ifdef SHA2_PAD_BLKCNT_EN
  logic [15:0] r_blk_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_start)
      r_blk_cnt <= '0;
    else if (w_emit && r_wcnt == 4'd15 && !w_msg_end && r_blk_cnt != '1)
      r_blk_cnt <= r_blk_cnt + 16'd1;
  end

  assign bus.blk_cnt = r_blk_cnt;
`endif
endmodule
